// File: rtl/wb_port_arbiter_if.sv
// Bundle of requester-side and slave-side signals shared by wb_port_arbiter.
// The arbiter takes the slave modport; the environment (caches + memory) takes master.
interface wb_port_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_i;
    logic [NREQ-1:0]    we_i;
    logic [NREQ*32-1:0] addr_i;
    logic [NREQ*32-1:0] wdata_i;
    logic [NREQ-1:0]    gnt_o;
    logic [NREQ-1:0]    rvalid_o;
    logic               rerr_o;
    logic [31:0]        rdata_o;
    logic               bus_req;
    logic               bus_we;
    logic [31:0]        bus_addr;
    logic [31:0]        bus_wdata;
    logic [31:0]        bus_rdata;
    logic               bus_valid;
    logic               bus_busy;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, bus_rdata, bus_valid, bus_busy,
        output gnt_o, rvalid_o, rerr_o, rdata_o, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, bus_rdata, bus_valid, bus_busy,
        input  gnt_o, rvalid_o, rerr_o, rdata_o, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin (optionally requester-0-priority) arbiter sharing one wishbone-style
// memory port; one transaction in flight, watchdog-terminated if the slave never answers.
module wb_port_arbiter #(
    parameter int NREQ    = 3,
    parameter int PRIO0   = 1,
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  io_bus
);
    localparam int unsigned NR = NREQ;
    localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_owner, w_owner_nxt;
    logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [CW-1:0]   r_wdog, w_wdog_nxt;
    logic            r_bus_we, w_bus_we_nxt;
    logic [31:0]     r_bus_addr, w_bus_addr_nxt;
    logic [31:0]     r_bus_wdata, w_bus_wdata_nxt;

    logic [PW-1:0]   w_win;
    logic [31:0]     w_addr_arr  [NREQ];
    logic [31:0]     w_wdata_arr [NREQ];
    logic [NREQ-1:0] w_gnt, w_rvalid;
    logic            w_rerr, w_bus_req;
    logic [31:0]     w_rdata;

    // Scan farthest-to-nearest from ptr so the last hit is the first set bit at/after ptr.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [PW-1:0]   ptr);
        int unsigned idx;
        rr_pick = ptr;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = (32'(ptr) + NR - 1 - i) % NR;
            if (req[idx]) rr_pick = PW'(idx);
        end
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NR; i++) begin
            w_addr_arr[i]  = io_bus.addr_i[32*i +: 32];
            w_wdata_arr[i] = io_bus.wdata_i[32*i +: 32];
        end
    end

    always_comb begin
        w_win = rr_pick(io_bus.req_i, r_rr_ptr);
        if (PRIO0 != 0 && io_bus.req_i[0]) w_win = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_wdog      <= '0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_wdog      <= w_wdog_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_wdog_nxt      = r_wdog;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_gnt           = '0;
        w_rvalid        = '0;
        w_rerr          = 1'b0;
        w_rdata         = '0;
        w_bus_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|io_bus.req_i) begin
                    w_owner_nxt     = w_win;
                    w_bus_we_nxt    = io_bus.we_i[w_win];
                    w_bus_addr_nxt  = w_addr_arr[w_win];
                    w_bus_wdata_nxt = w_wdata_arr[w_win];
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!io_bus.bus_busy) begin
                    w_bus_req        = 1'b1;
                    w_gnt[r_owner]   = 1'b1;
                    w_rr_ptr_nxt     = (r_owner == PW'(NR - 1)) ? '0 : r_owner + PW'(1);
                    w_wdog_nxt       = '0;
                    w_state_nxt      = S_WAIT;
                end
            end
            S_WAIT: begin
                w_wdog_nxt = r_wdog + CW'(1);
                if (io_bus.bus_valid) begin
                    w_rvalid[r_owner] = 1'b1;
                    w_rdata           = io_bus.bus_rdata;
                    w_state_nxt       = S_IDLE;
                end else if (r_wdog == CW'(TIMEOUT - 1)) begin
                    w_rvalid[r_owner] = 1'b1;
                    w_rerr            = 1'b1;
                    w_state_nxt       = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign io_bus.gnt_o     = w_gnt;
    assign io_bus.rvalid_o  = w_rvalid;
    assign io_bus.rerr_o    = w_rerr;
    assign io_bus.rdata_o   = w_rdata;
    assign io_bus.bus_req   = w_bus_req;
    assign io_bus.bus_we    = r_bus_we;
    assign io_bus.bus_addr  = r_bus_addr;
    assign io_bus.bus_wdata = r_bus_wdata;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: PRIO0=1 arbiter (dut_a) and PRIO0=0 arbiter (dut_b), each behind a
// three-cycle-latency memory model.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.NREQ(3)) ifa ();
    wb_port_arbiter_if #(.NREQ(3)) ifb ();

    wb_port_arbiter #(.NREQ(3), .PRIO0(1), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst), .io_bus(ifa.slave));
    wb_port_arbiter #(.NREQ(3), .PRIO0(0), .TIMEOUT(64)) dut_b (
        .clk(clk), .rst(rst), .io_bus(ifb.slave));

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    // Memory model: bus_req seen in cycle t gives bus_valid in cycle t+3.
    logic        sa_valid = 1'b0, sa_inject = 1'b0, sa_mute = 1'b0;
    logic [31:0] sa_rdata = '0, sa_addr = '0;
    logic        sa_seen;
    logic [31:0] sa_seen_addr;
    int          sa_cnt = 0;
    assign ifa.bus_valid = sa_valid | sa_inject;
    assign ifa.bus_rdata = sa_rdata;

    always begin
        @(posedge clk);
        sa_seen      = ifa.bus_req;
        sa_seen_addr = ifa.bus_addr;
        @(negedge clk);
        sa_valid = 1'b0;
        if (sa_cnt != 0) begin
            sa_cnt = sa_cnt - 1;
            if (sa_cnt == 0 && !sa_mute) begin
                sa_valid = 1'b1;
                sa_rdata = memval(sa_addr);
            end
        end
        if (sa_seen) begin
            sa_cnt  = 2;
            sa_addr = sa_seen_addr;
        end
    end

    logic        sb_valid = 1'b0;
    logic [31:0] sb_rdata = '0, sb_addr = '0;
    logic        sb_seen;
    logic [31:0] sb_seen_addr;
    int          sb_cnt = 0;
    assign ifb.bus_valid = sb_valid;
    assign ifb.bus_rdata = sb_rdata;

    always begin
        @(posedge clk);
        sb_seen      = ifb.bus_req;
        sb_seen_addr = ifb.bus_addr;
        @(negedge clk);
        sb_valid = 1'b0;
        if (sb_cnt != 0) begin
            sb_cnt = sb_cnt - 1;
            if (sb_cnt == 0) begin
                sb_valid = 1'b1;
                sb_rdata = memval(sb_addr);
            end
        end
        if (sb_seen) begin
            sb_cnt  = 2;
            sb_addr = sb_seen_addr;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        ifa.req_i  = 3'b111;
        ifa.we_i   = 3'b111;
        ifa.addr_i = {3{32'hDEAD_BEE0}};
        ifb.req_i  = 3'b111;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ifa.gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", ifa.gnt_o); end
        checks++; if (ifa.rvalid_o !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b want 000", ifa.rvalid_o); end
        checks++; if (ifa.rerr_o !== 1'b0) begin errors++; $display("FAIL reset_rerr: got %b want 0", ifa.rerr_o); end
        checks++; if (ifa.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ifa.rdata_o); end
        checks++; if (ifa.bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", ifa.bus_req); end
        checks++; if (ifa.bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we: got %b want 0", ifa.bus_we); end
        checks++; if (ifa.bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h want 0", ifa.bus_addr); end
        checks++; if (ifa.bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata: got %h want 0", ifa.bus_wdata); end
        checks++; if (ifb.gnt_o !== 3'b000 || ifb.bus_req !== 1'b0) begin errors++; $display("FAIL reset_b: got gnt=%b req=%b want 000/0", ifb.gnt_o, ifb.bus_req); end
        @(negedge clk);
        ifa.req_i = '0; ifa.we_i = '0; ifa.addr_i = '0;
        ifb.req_i = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read();
        @(negedge clk);
        ifa.req_i = 3'b010;
        ifa.addr_i[63:32] = 32'h40;
        #1;
        checks++; if (ifa.gnt_o !== 3'b000 || ifa.bus_req !== 1'b0) begin errors++; $display("FAIL read_idle: got gnt=%b req=%b want 000/0", ifa.gnt_o, ifa.bus_req); end
        @(negedge clk); #1;
        checks++; if (ifa.gnt_o !== 3'b010) begin errors++; $display("FAIL read_gnt: got %b want 010", ifa.gnt_o); end
        checks++; if (ifa.bus_req !== 1'b1 || ifa.bus_addr !== 32'h40 || ifa.bus_we !== 1'b0) begin errors++; $display("FAIL read_bus: got req=%b addr=%h we=%b want 1/40/0", ifa.bus_req, ifa.bus_addr, ifa.bus_we); end
        ifa.req_i = 3'b000;
        repeat (2) begin
            @(negedge clk); #1;
            checks++; if (ifa.rvalid_o !== 3'b000) begin errors++; $display("FAIL read_early: got %b want 000", ifa.rvalid_o); end
        end
        @(negedge clk); #1;
        checks++; if (ifa.rvalid_o !== 3'b010) begin errors++; $display("FAIL read_rvalid: got %b want 010", ifa.rvalid_o); end
        checks++; if (ifa.rdata_o !== 32'hC0DE_0040 || ifa.rerr_o !== 1'b0) begin errors++; $display("FAIL read_data: got %h err=%b want c0de0040/0", ifa.rdata_o, ifa.rerr_o); end
        @(negedge clk); #1;
        checks++; if (ifa.rvalid_o !== 3'b000) begin errors++; $display("FAIL read_after: got %b want 000", ifa.rvalid_o); end
    endtask

    task automatic test_write();
        int n;
        @(negedge clk);
        ifa.req_i = 3'b100;
        ifa.we_i  = 3'b100;
        ifa.addr_i[95:64]  = 32'h80;
        ifa.wdata_i[95:64] = 32'h1234_5678;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (ifa.gnt_o === 3'b000 && n < 10);
        checks++; if (ifa.gnt_o !== 3'b100) begin errors++; $display("FAIL write_gnt: got %b want 100", ifa.gnt_o); end
        checks++; if (ifa.bus_we !== 1'b1 || ifa.bus_addr !== 32'h80 || ifa.bus_wdata !== 32'h1234_5678) begin errors++; $display("FAIL write_bus: got we=%b addr=%h wd=%h want 1/80/12345678", ifa.bus_we, ifa.bus_addr, ifa.bus_wdata); end
        ifa.req_i = 3'b000; ifa.we_i = 3'b000;
        ifa.addr_i[95:64] = 32'hFFFF_0000;
        @(negedge clk); #1;
        checks++; if (ifa.bus_addr !== 32'h80) begin errors++; $display("FAIL write_hold: got %h want 80", ifa.bus_addr); end
        n = 0;
        while (ifa.rvalid_o === 3'b000 && n < 10) begin @(negedge clk); #1; n++; end
        checks++; if (ifa.rvalid_o !== 3'b100 || ifa.rerr_o !== 1'b0 || ifa.rdata_o !== 32'hC0DE_0080) begin errors++; $display("FAIL write_done: got rv=%b err=%b d=%h want 100/0/c0de0080", ifa.rvalid_o, ifa.rerr_o, ifa.rdata_o); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n;
        logic [2:0] exp;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            ifb.req_i = 3'b111;
            for (int k = 0; k < 3; k++) begin
                exp = 3'b001 << k;
                n = 0;
                do begin @(negedge clk); #1; n++; end while (ifb.gnt_o === 3'b000 && n < 20);
                checks++; if (ifb.gnt_o !== exp) begin errors++; $display("FAIL rr_gnt r%0d k%0d: got %b want %b", r, k, ifb.gnt_o, exp); end
                ifb.req_i = ifb.req_i & ~exp;
                n = 0;
                do begin @(negedge clk); #1; n++; end while (ifb.rvalid_o === 3'b000 && n < 20);
                checks++; if (ifb.rvalid_o !== exp) begin errors++; $display("FAIL rr_rvalid r%0d k%0d: got %b want %b", r, k, ifb.rvalid_o, exp); end
            end
        end
        @(negedge clk);
    endtask

    // Requesters 1 and 2 held; requester 0 pulsed on transactions 3 and 5 (rr_ptr starts at 0).
    task automatic test_priority();
        int n;
        int   wexp [6] = '{1, 2, 0, 1, 0, 1};
        logic p0   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] exp;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ifa.req_i = {2'b11, p0[i]};
            exp = 3'b001 << wexp[i];
            n = 0;
            do begin @(negedge clk); #1; n++; end while (ifa.gnt_o === 3'b000 && n < 20);
            checks++; if (ifa.gnt_o !== exp) begin errors++; $display("FAIL prio_gnt t%0d: got %b want %b", i, ifa.gnt_o, exp); end
            ifa.req_i[0] = 1'b0;
            n = 0;
            do begin @(negedge clk); #1; n++; end while (ifa.rvalid_o === 3'b000 && n < 20);
            checks++; if (ifa.rvalid_o !== exp) begin errors++; $display("FAIL prio_rvalid t%0d: got %b want %b", i, ifa.rvalid_o, exp); end
        end
        ifa.req_i = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_stall();
        int n;
        @(negedge clk);
        ifa.bus_busy = 1'b1;
        ifa.req_i    = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if (ifa.bus_req !== 1'b0 || ifa.gnt_o !== 3'b000) begin errors++; $display("FAIL busy_stall c%0d: got req=%b gnt=%b want 0/000", i, ifa.bus_req, ifa.gnt_o); end
        end
        @(negedge clk);
        ifa.bus_busy = 1'b0;
        #1;
        checks++; if (ifa.bus_req !== 1'b1 || ifa.gnt_o !== 3'b001) begin errors++; $display("FAIL busy_release: got req=%b gnt=%b want 1/001", ifa.bus_req, ifa.gnt_o); end
        @(negedge clk);
        ifa.req_i = 3'b000;
        n = 0;
        while (ifa.rvalid_o === 3'b000 && n < 10) begin @(negedge clk); #1; n++; end
        checks++; if (ifa.rvalid_o !== 3'b001) begin errors++; $display("FAIL busy_done: got %b want 001", ifa.rvalid_o); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        sa_mute = 1'b1;
        @(negedge clk);
        ifa.req_i = 3'b100;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (ifa.bus_req !== 1'b1 && n < 10);
        checks++; if (ifa.bus_req !== 1'b1) begin errors++; $display("FAIL to_issue: got %b want 1", ifa.bus_req); end
        ifa.req_i = 3'b000;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 70) sa_inject = 1'b1;
            #1;
            if (k == 64) begin
                checks++; if (ifa.rvalid_o !== 3'b100 || ifa.rerr_o !== 1'b1 || ifa.rdata_o !== 32'h0) begin errors++; $display("FAIL to_fire: got rv=%b err=%b d=%h want 100/1/0", ifa.rvalid_o, ifa.rerr_o, ifa.rdata_o); end
            end else begin
                checks++; if (ifa.rvalid_o !== 3'b000) begin errors++; $display("FAIL to_quiet k%0d: got %b want 000", k, ifa.rvalid_o); end
            end
        end
        @(negedge clk);
        sa_inject = 1'b0;
        sa_mute   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int n;
        @(negedge clk);
        ifa.req_i = 3'b010;
        ifa.addr_i[63:32] = 32'h44;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (ifa.gnt_o === 3'b000 && n < 10);
        checks++; if (ifa.gnt_o !== 3'b010) begin errors++; $display("FAIL rmw_gnt: got %b want 010", ifa.gnt_o); end
        ifa.req_i = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ifa.bus_addr !== 32'h0 || ifa.bus_req !== 1'b0 || ifa.rvalid_o !== 3'b000 || ifa.gnt_o !== 3'b000) begin errors++; $display("FAIL rmw_zero: got addr=%h req=%b rv=%b gnt=%b want 0", ifa.bus_addr, ifa.bus_req, ifa.rvalid_o, ifa.gnt_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++; if (ifa.rvalid_o !== 3'b000) begin errors++; $display("FAIL rmw_stale k%0d: got %b want 000", k, ifa.rvalid_o); end
        end
        ifa.req_i = 3'b110;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (ifa.gnt_o === 3'b000 && n < 10);
        checks++; if (ifa.gnt_o !== 3'b010) begin errors++; $display("FAIL rmw_regrant: got %b want 010", ifa.gnt_o); end
        ifa.req_i = 3'b000;
        n = 0;
        while (ifa.rvalid_o === 3'b000 && n < 10) begin @(negedge clk); #1; n++; end
        checks++; if (ifa.rvalid_o !== 3'b010 || ifa.rdata_o !== 32'hC0DE_0044) begin errors++; $display("FAIL rmw_done: got rv=%b d=%h want 010/c0de0044", ifa.rvalid_o, ifa.rdata_o); end
        @(negedge clk);
    endtask

    initial begin
        ifa.req_i = '0; ifa.we_i = '0; ifa.addr_i = '0; ifa.wdata_i = '0; ifa.bus_busy = 1'b0;
        ifb.req_i = '0; ifb.we_i = '0; ifb.addr_i = '0; ifb.wdata_i = '0; ifb.bus_busy = 1'b0;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_priority();
        test_busy_stall();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares one wishbone memory port between NREQ requesters:
  - req 0: icache miss fetch
  - req 1: icache refill
  - req 2: dcache
- Serialises transactions with one outstanding at a time, picks the winner by round-robin with optional fixed top priority for requester 0, and routes the response back to the owner.
- A watchdog terminates transactions the slave never answers.
- Sits between the caches and a single wb_simulator-style slave (req/we/addr/wdata in; rdata/valid/busy out).

Parameters:
- NREQ, 3: number of requesters (2..8).
- PRIO0, 1: 1 = requester 0 always wins when requesting; 0 = pure round-robin.
- TIMEOUT, 64: cycles in WAIT before forced error completion (must be at least 4).
- CW, $clog2(TIMEOUT+1): watchdog counter width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_i  in  NREQ  per-requester request level; held until gnt_o
- we_i  in  NREQ  per-requester write enable
- addr_i  in  NREQ*32  packed addresses; slot k = bits [32k+31:32k]
- wdata_i  in  NREQ*32  packed write data
- gnt_o  out  NREQ  one-cycle pulse; request accepted
- rvalid_o  out  NREQ  one-cycle completion pulse to owner
- rerr_o  out  1  qualifies rvalid_o; 1 = timeout
- rdata_o  out  32  response data, broadcast; valid only with rvalid_o
- bus_req  out  1  one-cycle transaction strobe to slave
- bus_we  out  1  slave write enable
- bus_addr  out  32  slave address
- bus_wdata  out  32  slave write data
- bus_rdata  in  32  slave read data
- bus_valid  in  1  slave completion pulse
- bus_busy  in  1  slave busy; issue is blocked while high

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0, wdog = 0.
  - All outputs are 0: gnt_o, rvalid_o, rerr_o, rdata_o, bus_req, bus_we, bus_addr, bus_wdata.
  - Reset is asynchronous and may arrive mid-transaction: it aborts the transaction silently and the owner gets no rvalid_o.
- State machine:
  - IDLE:
    - If any req_i is set, select the winner:
      - PRIO0=1 and req_i[0] set: winner = 0.
      - Otherwise: first set bit scanning from rr_ptr upward, wrapping modulo NREQ.
    - Register owner and latch that requester's we/addr/wdata into the bus registers, then go to ISSUE.
    - bus_valid is ignored in IDLE; it counts as a stale response.
  - ISSUE:
    - If bus_busy = 1, stay in ISSUE with no strobe.
    - Otherwise: bus_req = 1, gnt_o[owner] = 1 (same cycle), rr_ptr <= (owner+1) mod NREQ, wdog <= 0, go to WAIT.
  - WAIT:
    - wdog increments every cycle.
    - If bus_valid = 1: rvalid_o[owner] = 1, rdata_o = bus_rdata, rerr_o = 0. This is combinational, in the same cycle. Go to IDLE.
    - Else if wdog = TIMEOUT-1: rvalid_o[owner] = 1, rerr_o = 1, rdata_o = 0, go to IDLE.
    - A bus_valid that arrives later lands in IDLE and is dropped.
- Latency:
  - req_i set in cycle t with the arbiter IDLE and the slave not busy: bus_req and gnt_o in t+1.
  - Response cycle = bus_valid cycle.
  - Minimum turnaround between back-to-back grants is slave latency + 2 cycles.
- Request rules:
  - Requesters hold req/we/addr/wdata stable until gnt_o.
  - Fields are sampled only on the IDLE→ISSUE edge; later changes do not affect the in-flight transaction.
  - A requester that deasserts req_i before being selected is simply not considered.
  - A requester must deassert req_i in the cycle after gnt_o, otherwise it re-requests.
- Read/write:
  - Writes complete via bus_valid exactly like reads.
  - rdata_o is don't-care for writes but is still forwarded.
- Outputs: gnt_o and rvalid_o are one-hot or zero at all times.

Test Plan:
- Single read: reset, then req_i=3'b010, addr_i[1]=0x40, slave LATENCY=3 → gnt_o=3'b010 and bus_req with bus_addr=0x40 one cycle later; rvalid_o=3'b010 with rdata_o equal to mem[0x40>>2] 3 cycles after bus_req; rerr_o=0.
- Round-robin, PRIO0=0: req_i=3'b111 held, each requester drops req after its own grant → grant order 0,1,2; then re-raising all three gives 0,1,2 again with rr_ptr wrapping to 0.
- Priority, PRIO0=1: req_i[1] and req_i[2] held continuously while req_i[0] pulses once per transaction → requester 0 wins every arbitration it is present in; requesters 1 and 2 alternate otherwise.
- Timeout: slave never asserts bus_valid, TIMEOUT=64 → rvalid_o[owner]=1, rerr_o=1, rdata_o=0 exactly 64 cycles after bus_req; a late bus_valid at cycle 70 produces no rvalid_o.
- Busy stall: bus_busy=1 for 5 cycles while in ISSUE → no bus_req and no gnt_o during those cycles; both assert in the first cycle bus_busy=0.
- Reset mid-WAIT: assert rst 1 cycle after bus_req → all outputs 0 immediately; the slave's later bus_valid is ignored; the next request is granted normally, starting from rr_ptr=0.
